// File: rtl/vector_output_serializer.sv
// Buffers CPU output vectors and streams them lane by lane; first beat two cycles after the strobe edge.
// stallRequest once count>=FIFO_DEPTH-1; beats hold under !laneReady. `VOS_SEQ_HEADER_EN adds a sequence header beat.
module vector_output_serializer #(
  parameter int DATA_WIDTH       = 19,
  parameter int VECTOR_SIZE      = 6,
  parameter int FIFO_DEPTH       = 4,
  parameter int LANE_INDEX_WIDTH = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                outFlag,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]   out,
  output logic                                stallRequest,
  output logic [DATA_WIDTH-1:0]               laneData,
  output logic                                laneValid,
  input  logic                                laneReady,
  output logic [LANE_INDEX_WIDTH-1:0]         laneIndex,
  output logic                                laneLast,
  output logic [$clog2(FIFO_DEPTH):0]         fifoCount,
  output logic                                overflow
`ifdef VOS_SEQ_HEADER_EN
  ,
  output logic                                laneHeader
`endif
);

  localparam int VEC_W = VECTOR_SIZE * DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [LANE_INDEX_WIDTH-1:0] LAST_LANE = LANE_INDEX_WIDTH'(VECTOR_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LANES, S_HEADER} state_t;

  state_t                      r_state;
  logic [VEC_W-1:0]            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_overflow;
  logic                        r_valid;
  logic [DATA_WIDTH-1:0]       r_data;
  logic [LANE_INDEX_WIDTH-1:0] r_lane;
  logic                        r_last;
`ifdef VOS_SEQ_HEADER_EN
  logic                        r_hdr;
  logic [DATA_WIDTH-1:0]       r_seq;
`endif

  logic                        w_full;
  logic                        w_push;
  logic                        w_xfer;
  logic                        w_pop;
  logic [CNT_W-1:0]            w_count_nxt;
  logic [PTR_W-1:0]            w_rd_ptr_nxt;
  logic [LANE_INDEX_WIDTH-1:0] w_lane_nxt;
  logic [VEC_W-1:0]            w_head;

  function automatic logic [DATA_WIDTH-1:0] f_lane(input logic [VEC_W-1:0] v,
                                                   input logic [LANE_INDEX_WIDTH-1:0] idx);
    f_lane = '0;
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      if (idx == LANE_INDEX_WIDTH'(k)) f_lane = v[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endfunction

  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push       = outFlag && !w_full;
  assign w_xfer       = r_valid && laneReady;
  assign w_pop        = w_xfer && (r_state == S_LANES) && (r_lane == LAST_LANE);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
  assign w_lane_nxt   = r_lane + LANE_INDEX_WIDTH'(1);
  assign w_head       = r_mem[r_rd_ptr];

`ifndef VOS_SEQ_HEADER_EN
  // A vector pushed on the same edge as the pop of the sole entry is not in memory yet.
  logic [VEC_W-1:0] w_next_vec;
  assign w_next_vec = (r_count == CNT_W'(1)) ? out : r_mem[w_rd_ptr_nxt];
`endif

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= out;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_lane     <= '0;
      r_last     <= 1'b0;
`ifdef VOS_SEQ_HEADER_EN
      r_hdr      <= 1'b0;
      r_seq      <= '0;
`endif
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= w_rd_ptr_nxt;
      if (outFlag && w_full) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_valid <= 1'b1;
            r_lane  <= '0;
`ifdef VOS_SEQ_HEADER_EN
            r_state <= S_HEADER;
            r_hdr   <= 1'b1;
            r_data  <= r_seq;
            r_last  <= 1'b0;
`else
            r_state <= S_LANES;
            r_data  <= f_lane(w_head, LANE_INDEX_WIDTH'(0));
            r_last  <= (LAST_LANE == '0);
`endif
          end
        end
`ifdef VOS_SEQ_HEADER_EN
        S_HEADER: begin
          if (w_xfer) begin
            r_state <= S_LANES;
            r_hdr   <= 1'b0;
            r_data  <= f_lane(w_head, LANE_INDEX_WIDTH'(0));
            r_last  <= (LAST_LANE == '0);
          end
        end
`endif
        S_LANES: begin
          if (w_xfer) begin
            if (r_lane != LAST_LANE) begin
              r_lane <= w_lane_nxt;
              r_data <= f_lane(w_head, w_lane_nxt);
              r_last <= (w_lane_nxt == LAST_LANE);
            end else begin
              r_lane <= '0;
`ifdef VOS_SEQ_HEADER_EN
              r_seq  <= r_seq + DATA_WIDTH'(1);
`endif
              if (w_count_nxt != '0) begin
`ifdef VOS_SEQ_HEADER_EN
                r_state <= S_HEADER;
                r_hdr   <= 1'b1;
                r_data  <= r_seq + DATA_WIDTH'(1);
                r_last  <= 1'b0;
`else
                r_data  <= f_lane(w_next_vec, LANE_INDEX_WIDTH'(0));
                r_last  <= (LAST_LANE == '0);
`endif
              end else begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stallRequest = (r_count >= CNT_W'(FIFO_DEPTH - 1));
  assign fifoCount    = r_count;
  assign overflow     = r_overflow;
  assign laneValid    = r_valid;
  assign laneData     = r_data;
  assign laneIndex    = r_lane;
  assign laneLast     = r_last;
`ifdef VOS_SEQ_HEADER_EN
  assign laneHeader   = r_hdr;
`endif

endmodule

// File: tb/tb_vector_output_serializer.sv
// Directed bench for vector_output_serializer: scoreboard of expected beats checked on every transfer.
module tb_vector_output_serializer;

  localparam int DW = 19;
  localparam int VS = 6;
  localparam int LW = 3;
  localparam int VW = VS * DW;
`ifdef VOS_SEQ_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int BEATS = VS + (HDR ? 1 : 0);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [LW-1:0] idx;
    logic          last;
    logic          hdr;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          outFlag;
  logic [VW-1:0] vec_in;
  logic          stallRequest;
  logic [DW-1:0] laneData;
  logic          laneValid;
  logic          laneReady;
  logic [LW-1:0] laneIndex;
  logic          laneLast;
  logic [2:0]    fifoCount;
  logic          overflow;
  logic          laneHeader;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            beat_total = 0;
  int            last_xfer_cyc = 0;
  beat_t         sb[$];
  beat_t         mon_got;
  beat_t         mon_exp;
  logic [DW-1:0] tb_seq;

  vector_output_serializer dut (
    .clock        (clock),
    .reset        (reset),
    .outFlag      (outFlag),
    .out          (vec_in),
    .stallRequest (stallRequest),
    .laneData     (laneData),
    .laneValid    (laneValid),
    .laneReady    (laneReady),
    .laneIndex    (laneIndex),
    .laneLast     (laneLast),
    .fifoCount    (fifoCount),
    .overflow     (overflow)
`ifdef VOS_SEQ_HEADER_EN
    ,
    .laneHeader   (laneHeader)
`endif
  );

`ifndef VOS_SEQ_HEADER_EN
  assign laneHeader = 1'b0;
`endif

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < VS; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [VW-1:0] v);
    beat_t b;
    if (HDR) begin
      b = '{d: tb_seq, idx: '0, last: 1'b0, hdr: 1'b1};
      sb.push_back(b);
    end
    tb_seq = tb_seq + 1'b1;
    for (int k = 0; k < VS; k++) begin
      b = '{d: v[k*DW +: DW], idx: LW'(k), last: (k == VS - 1), hdr: 1'b0};
      sb.push_back(b);
    end
  endtask

  // Called at posedge+#1; the strobe is sampled on the next rising edge.
  task automatic send(input logic [VW-1:0] v, input bit accepted);
    outFlag = 1'b1;
    vec_in  = v;
    if (accepted) push_exp(v);
    @(posedge clock); #1;
    outFlag = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!laneValid && fifoCount == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    int  run_len;
    int  b0;
    int  c0;
    bit  found;
    logic [VW-1:0] v;

    reset = 1'b1; outFlag = 1'b0; vec_in = '0; laneReady = 1'b0; tb_seq = '0;

    fork
      forever begin
        @(negedge clock);
        if (!reset && laneValid && laneReady) begin
          beat_total++;
          last_xfer_cyc = cyc;
          mon_got = {laneData, laneIndex, laneLast, laneHeader};
          checks++;
          assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL beat_unexpected observed=%h expected=none", mon_got);
          end
          if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            checks++;
            assert (mon_got === mon_exp) else begin
              failures++;
              $error("FAIL beat observed=%h expected=%h", mon_got, mon_exp);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(laneValid), 32'd0);
    chk("rst_data", 32'(laneData), 32'd0);
    chk("rst_index", 32'(laneIndex), 32'd0);
    chk("rst_last", 32'(laneLast), 32'd0);
    chk("rst_count", 32'(fifoCount), 32'd0);
    chk("rst_stall", 32'(stallRequest), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Single vector: lanes 1..6, first beat in the cycle after the edge following the strobe.
    laneReady = 1'b1;
    send(mkvec(1), 1'b1);
    chk("single_count1", 32'(fifoCount), 32'd1);
    chk("single_novalid_yet", 32'(laneValid), 32'd0);
    @(posedge clock); #1;
    chk("single_first_valid", 32'(laneValid), 32'd1);
    chk("single_first_index", 32'(laneIndex), 32'd0);
    run_len = 0;
    for (int i = 0; i < 200; i++) begin
      if (!laneValid) break;
      run_len++;
      @(posedge clock); #1;
    end
    chk("single_run_len", 32'(run_len), 32'(BEATS));
    chk("single_count0", 32'(fifoCount), 32'd0);

    // Backpressure at lane 2 for 5 cycles.
    v = mkvec(100);
    send(v, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (laneValid && !laneHeader && laneIndex == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_reach_lane2", 32'(found), 32'd1);
    laneReady = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      chk("bp_hold_valid", 32'(laneValid), 32'd1);
      chk("bp_hold_index", 32'(laneIndex), 32'd2);
      chk("bp_hold_data", 32'(laneData), 32'(v[2*DW +: DW]));
    end
    laneReady = 1'b1;
    wait_idle("bp_idle");
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Fill and overflow: five strobes with the consumer stalled.
    laneReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(mkvec(1000 + 10 * i), (i < 4));
      chk("fill_count", 32'(fifoCount), 32'((i < 4) ? i + 1 : 4));
      chk("fill_stall", 32'(stallRequest), 32'((i >= 2) ? 1 : 0));
    end
    chk("fill_overflow", 32'(overflow), 32'd1);
    laneReady = 1'b1;
    wait_idle("fill_idle");
    chk("fill_sb_empty", 32'(sb.size()), 32'd0);
    chk("fill_overflow_sticky", 32'(overflow), 32'd1);

    // Back-to-back: three vectors, no gap cycles.
    b0 = beat_total;
    send(mkvec(200), 1'b1);
    c0 = cyc;
    send(mkvec(300), 1'b1);
    send(mkvec(400), 1'b1);
    wait_idle("b2b_idle");
    chk("b2b_beats", 32'(beat_total - b0), 32'(3 * BEATS));
    chk("b2b_span", 32'(last_xfer_cyc - c0), 32'(3 * BEATS));

    // Strobe lands on the edge that pops the only buffered vector.
    b0 = beat_total;
    send(mkvec(500), 1'b1);
    c0 = cyc;
    repeat (BEATS) @(posedge clock);
    #1;
    send(mkvec(600), 1'b1);
    wait_idle("bypass_idle");
    chk("bypass_beats", 32'(beat_total - b0), 32'(2 * BEATS));
    chk("bypass_span", 32'(last_xfer_cyc - c0), 32'(2 * BEATS));

    // Reset mid-vector with two entries buffered.
    laneReady = 1'b0;
    send(mkvec(700), 1'b1);
    send(mkvec(800), 1'b1);
    chk("rmid_count2", 32'(fifoCount), 32'd2);
    laneReady = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (laneValid && !laneHeader && laneIndex == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("rmid_reach_lane3", 32'(found), 32'd1);
    reset = 1'b1;
    sb.delete();
    tb_seq = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rmid_valid0", 32'(laneValid), 32'd0);
    chk("rmid_count0", 32'(fifoCount), 32'd0);
    chk("rmid_overflow0", 32'(overflow), 32'd0);
    chk("rmid_stall0", 32'(stallRequest), 32'd0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("rmid_quiet", 32'(laneValid), 32'd0);
    end
    send(mkvec(900), 1'b1);
    @(posedge clock); #1;
    chk("rmid_restart_valid", 32'(laneValid), 32'd1);
    chk("rmid_restart_index", 32'(laneIndex), 32'd0);
    wait_idle("rmid_idle");
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
